fmad_arbiter: RTL and testbench
===============================

Name: fmad_arbiter

Overview:
- Shares one fmad datapath (WIDTH-bit multiply, 2*WIDTH-bit add/sub, optional negate) among NUM_REQ requesters.
- Accepts one operation at a time via per-requester valid/ready, chosen round-robin.
- Drives fmad's start/operand interface, waits for fmadDone and returns the tagged result on one response channel with backpressure and a watchdog timeout.
- Sits between the issue logic and the fmad instance, so the fmad needs no arbitration of its own.

Parameters:
- WIDTH, 8: multiplier operand width; result/addend width is 2*WIDTH.
- NUM_REQ, 4: number of requesters (>=2); ID width is $clog2(NUM_REQ).
- TIMEOUT, 64: maximum cycles in WAIT before an error response (>=2).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  request valid, one bit per requester.
- reqReady  out  NUM_REQ  request accepted, one-hot or zero.
- reqMulIn1  in  NUM_REQ*WIDTH  multiplicand, requester i at slice [i*WIDTH +: WIDTH].
- reqMulIn2  in  NUM_REQ*WIDTH  multiplier, same packing.
- reqAddIn  in  NUM_REQ*2*WIDTH  addend, slice [i*2*WIDTH +: 2*WIDTH].
- reqSub  in  NUM_REQ  subtract flag per requester.
- reqNegate  in  NUM_REQ  negate flag per requester.
- rspValid  out  1  response valid.
- rspReady  in  1  response consumer ready.
- rspId  out  $clog2(NUM_REQ)  requester index of the response.
- rspData  out  2*WIDTH  fmad result (0 on error).
- rspErr  out  1  timeout error flag.
- fmadStart  out  1  one-cycle start pulse to the fmad.
- fmadMulIn1  out  WIDTH  to fmad.
- fmadMulIn2  out  WIDTH  to fmad.
- fmadAddIn  out  2*WIDTH  to fmad.
- fmadSub  out  1  to fmad.
- fmadNegate  out  1  to fmad.
- fmadDone  in  1  fmad completion.
- fmadOut  in  2*WIDTH  fmad result.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rrPtr=0, and all registered outputs 0: rspValid, rspId, rspData, rspErr, fmadStart, fmad operands/flags, timeout counter. Reset mid-operation abandons the op with no response; the fmad is not reset by this block.
- IDLE:
  - grant = first i with reqValid[i] set, scanning rrPtr, rrPtr+1, … modulo NUM_REQ.
  - reqReady[grant]=1 combinationally; all other reqReady bits are 0.
  - reqReady is 0 in every other state.
  - On handshake, latch operands, flags and the ID into the fmad operand registers, then go to ISSUE.
- ISSUE (exactly 1 cycle): fmadStart=1, registered outputs, so it is high the cycle after the handshake; go to WAIT, counter=0.
- WAIT:
  - Operands are held stable; fmadStart=0; the counter increments each cycle.
  - If fmadDone=1: rspData<=fmadOut, rspErr<=0, rspValid<=1, go to RESP.
  - Else if counter==TIMEOUT-1: rspData<=0, rspErr<=1, rspValid<=1, go to RESP.
  - fmadDone has priority over timeout in the same cycle.
- RESP:
  - rspValid, rspId, rspData and rspErr are held stable until rspReady=1.
  - On the rspValid&&rspReady cycle: rspValid<=0, rrPtr<=(rspId+1) mod NUM_REQ, go to IDLE.
  - The next grant is possible in the following cycle.
- Latency: handshake at cycle T → fmadStart at T+1 → done at T+1+L → rspValid at T+2+L; the minimum accept-to-accept period is L+3 cycles with rspReady tied high.
- fmadDone is ignored outside WAIT; a stray done never creates a response.
- Fairness: a continuously requesting requester is granted within NUM_REQ operations; with all requesters valid, the grant order is 0,1,2,3,0,…
- reqValid dropping without a handshake is legal and causes no state change.
- At most one operation is outstanding; there is no queueing.

Test Plan:
- Single op: req0 with m1=3, m2=4, a=5, sub=0, neg=0; bench fmad model with L=4 → fmadStart one cycle after the handshake, operands 3/4/5 on the fmad pins; rspValid 6 cycles after the handshake with rspId=0, rspData=17, rspErr=0.
- Round-robin: all four reqValid held high, rspReady=1 → grants in order 0,1,2,3,0; each reqReady one-hot and only in IDLE; rspId sequence matches.
- Backpressure: rspReady=0 for 10 cycles after rspValid → rspValid/rspData stable, no new reqReady; rspReady=1 → return to IDLE next cycle.
- Timeout: model never asserts fmadDone, TIMEOUT=64 → rspErr=1, rspData=0 exactly 64 cycles after entering WAIT; a later op completes normally.
- Flag passthrough and stray done: req2 with sub=1, neg=1, m1=255, m2=255, a=16'hFFFF → fmadSub=fmadNegate=1 and operands held for all of WAIT; a fmadDone pulse injected in IDLE produces no rspValid.
- Async reset in WAIT: deassert reset_n mid-op → outputs 0 immediately, rrPtr=0; after release, req1 alone is granted and completes correctly.

Source files
------------

// File: rtl/fmad_arbiter.sv
// rtl/fmad_arbiter.sv - round-robin front end sharing one fmad datapath among several requesters
module fmad_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                reqValid,
    output logic [NUM_REQ-1:0]                reqReady,
    input  logic [NUM_REQ*WIDTH-1:0]          reqMulIn1,
    input  logic [NUM_REQ*WIDTH-1:0]          reqMulIn2,
    input  logic [NUM_REQ*2*WIDTH-1:0]        reqAddIn,
    input  logic [NUM_REQ-1:0]                reqSub,
    input  logic [NUM_REQ-1:0]                reqNegate,
    output logic                              rspValid,
    input  logic                              rspReady,
    output logic [$clog2(NUM_REQ)-1:0]        rspId,
    output logic [2*WIDTH-1:0]                rspData,
    output logic                              rspErr,
    output logic                              fmadStart,
    output logic [WIDTH-1:0]                  fmadMulIn1,
    output logic [WIDTH-1:0]                  fmadMulIn2,
    output logic [2*WIDTH-1:0]                fmadAddIn,
    output logic                              fmadSub,
    output logic                              fmadNegate,
    input  logic                              fmadDone,
    input  logic [2*WIDTH-1:0]                fmadOut
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDW-1:0]    rrPtr;
    logic [CNTW-1:0]   waitCnt;

    logic [IDW-1:0]    grant;
    logic              grantFound;
    logic              accept;
    logic              doneHit;
    logic              timeoutHit;
    logic              rspFire;
    logic [IDW-1:0]    ptrAfterRsp;

    // Round-robin scan starting at rrPtr; wraps modulo NUM_REQ so non-power-of-two counts work
    always_comb begin
        grant      = '0;
        grantFound = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rrPtr) + k) % NUM_REQ;
            if (!grantFound && reqValid[idx]) begin
                grantFound = 1'b1;
                grant      = IDW'(idx);
            end
        end
    end

    // Ready is only offered while idle, and only to the winning requester
    always_comb begin
        reqReady = '0;
        if (state == IDLE && grantFound) begin
            reqReady[grant] = 1'b1;
        end
    end

    // Event decodes shared by the next-state logic and the datapath registers
    always_comb begin
        accept      = (state == IDLE) && grantFound;
        doneHit     = (state == WAIT) && fmadDone;
        timeoutHit  = (state == WAIT) && !fmadDone && (waitCnt == CNTW'(TIMEOUT - 1));
        rspFire     = (state == RESP) && rspReady;
        ptrAfterRsp = (rspId == IDW'(NUM_REQ - 1)) ? '0 : rspId + IDW'(1);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a done seen outside WAIT has no effect on the sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (doneHit || timeoutHit) state_next = RESP;
            RESP:    if (rspFire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and start pulse; operands stay put until the next accept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fmadStart  <= 1'b0;
            fmadMulIn1 <= '0;
            fmadMulIn2 <= '0;
            fmadAddIn  <= '0;
            fmadSub    <= 1'b0;
            fmadNegate <= 1'b0;
            rspId      <= '0;
        end else begin
            fmadStart <= accept;
            if (accept) begin
                fmadMulIn1 <= reqMulIn1[int'(grant)*WIDTH +: WIDTH];
                fmadMulIn2 <= reqMulIn2[int'(grant)*WIDTH +: WIDTH];
                fmadAddIn  <= reqAddIn[int'(grant)*2*WIDTH +: 2*WIDTH];
                fmadSub    <= reqSub[grant];
                fmadNegate <= reqNegate[grant];
                rspId      <= grant;
            end
        end
    end

    // Watchdog counter: cleared on the way into WAIT, counts every WAIT cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= '0;
        end else if (state == ISSUE) begin
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + CNTW'(1);
        end
    end

    // Response registers and round-robin pointer; pointer moves past the served requester
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rspValid <= 1'b0;
            rspData  <= '0;
            rspErr   <= 1'b0;
            rrPtr    <= '0;
        end else begin
            if (doneHit) begin
                rspValid <= 1'b1;
                rspData  <= fmadOut;
                rspErr   <= 1'b0;
            end else if (timeoutHit) begin
                rspValid <= 1'b1;
                rspData  <= '0;
                rspErr   <= 1'b1;
            end else if (rspFire) begin
                rspValid <= 1'b0;
                rrPtr    <= ptrAfterRsp;
            end
        end
    end

endmodule

// File: tb/tb_fmad_arbiter.sv
// tb/tb_fmad_arbiter.sv - self-checking bench for fmad_arbiter with a behavioural fmad model
module tb_fmad_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int L   = 4;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         reqValid;
    logic [N-1:0]         reqReady;
    logic [N*W-1:0]       reqMulIn1;
    logic [N*W-1:0]       reqMulIn2;
    logic [N*2*W-1:0]     reqAddIn;
    logic [N-1:0]         reqSub;
    logic [N-1:0]         reqNegate;
    logic                 rspValid;
    logic                 rspReady;
    logic [1:0]           rspId;
    logic [2*W-1:0]       rspData;
    logic                 rspErr;
    logic                 fmadStart;
    logic [W-1:0]         fmadMulIn1;
    logic [W-1:0]         fmadMulIn2;
    logic [2*W-1:0]       fmadAddIn;
    logic                 fmadSub;
    logic                 fmadNegate;
    logic                 fmadDone;
    logic [2*W-1:0]       fmadOut;

    logic [W-1:0]         m1 [N];
    logic [W-1:0]         m2 [N];
    logic [2*W-1:0]       ad [N];
    logic                 sb [N];
    logic                 ng [N];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int exp_ptr = 0;

    bit             mdl_en = 1'b1;
    bit             stray  = 1'b0;
    bit             pend   = 1'b0;
    int             mcnt   = 0;
    logic [2*W-1:0] mres   = '0;

    always #5 clock = ~clock;

    fmad_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqMulIn1(reqMulIn1), .reqMulIn2(reqMulIn2), .reqAddIn(reqAddIn),
        .reqSub(reqSub), .reqNegate(reqNegate),
        .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
        .rspData(rspData), .rspErr(rspErr),
        .fmadStart(fmadStart), .fmadMulIn1(fmadMulIn1), .fmadMulIn2(fmadMulIn2),
        .fmadAddIn(fmadAddIn), .fmadSub(fmadSub), .fmadNegate(fmadNegate),
        .fmadDone(fmadDone), .fmadOut(fmadOut)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqMulIn1[i*W +: W]     = m1[i];
            reqMulIn2[i*W +: W]     = m2[i];
            reqAddIn[i*2*W +: 2*W]  = ad[i];
            reqSub[i]               = sb[i];
            reqNegate[i]            = ng[i];
        end
    end

    function automatic logic [2*W-1:0] fmad_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [2*W-1:0] c, input logic s, input logic n);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = (2*W)'(a) * (2*W)'(b);
        r = s ? p - c : p + c;
        return n ? (2*W)'(0) - r : r;
    endfunction

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic rand_req(input int i);
        m1[i] = W'($urandom);
        m2[i] = W'($urandom);
        ad[i] = (2*W)'($urandom);
        sb[i] = 1'($urandom);
        ng[i] = 1'($urandom);
    endtask

    // One clock: advance to the falling edge, then step the fmad model (start -> done after L cycles)
    task automatic tick();
        @(negedge clock);
        cyc++;
        fmadDone = 1'b0;
        fmadOut  = (2*W)'($urandom);
        if (pend) begin
            mcnt--;
            if (mcnt == 0) begin
                pend     = 1'b0;
                fmadDone = mdl_en;
                fmadOut  = mres;
            end
        end
        if (fmadStart) begin
            pend = 1'b1;
            mcnt = L;
            mres = fmad_ref(fmadMulIn1, fmadMulIn2, fmadAddIn, fmadSub, fmadNegate);
        end
        if (stray) fmadDone = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (reqReady != '0) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output int n, output bit rdy_seen);
        n = -1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rspValid) begin
                n = i;
                break;
            end
            if (reqReady != '0) rdy_seen = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n  = 1'b0;
        reqValid = '0;
        rspReady = 1'b1;
        for (int i = 0; i < N; i++) rand_req(i);
        tick();
        tick();
        checks++;
        if (rspValid !== 1'b0 || rspErr !== 1'b0 || rspData !== '0 || rspId !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h id=%0d want all 0", rspValid, rspErr, rspData, rspId);
        end
        checks++;
        if (fmadStart !== 1'b0 || fmadMulIn1 !== '0 || fmadMulIn2 !== '0 || fmadAddIn !== '0 ||
            fmadSub !== 1'b0 || fmadNegate !== 1'b0) begin
            errors++;
            $display("FAIL reset_fmad: got st=%b %h %h %h %b %b want all 0", fmadStart, fmadMulIn1,
                     fmadMulIn2, fmadAddIn, fmadSub, fmadNegate);
        end
        checks++;
        if (reqReady !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", reqReady);
        end
        reset_n = 1'b1;
        exp_ptr = 0;
        tick();
        reqValid = 4'b1111;
        wait_grant(n);
        checks++;
        if (reqReady !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 0001", reqReady);
        end
        reqValid = '0;
    endtask

    task automatic test_single();
        int  n;
        bit  seen;
        m1[0] = 8'd3; m2[0] = 8'd4; ad[0] = 16'd5; sb[0] = 1'b0; ng[0] = 1'b0;
        reqValid = 4'b0001;
        wait_grant(n);
        checks++;
        if (reqReady !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", reqReady);
        end
        tick();
        reqValid = '0;
        checks++;
        if (fmadStart !== 1'b1 || fmadMulIn1 !== 8'd3 || fmadMulIn2 !== 8'd4 || fmadAddIn !== 16'd5) begin
            errors++;
            $display("FAIL single_issue: got st=%b %0d %0d %0d want 1 3 4 5", fmadStart, fmadMulIn1,
                     fmadMulIn2, fmadAddIn);
        end
        wait_rsp(n, seen);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL single_latency: got %0d want 5 cycles after issue", n);
        end
        checks++;
        if (rspId !== 2'd0 || rspData !== 16'd17 || rspErr !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got id=%0d d=%0d e=%b want 0 17 0", rspId, rspData, rspErr);
        end
        exp_ptr = 1;
        tick();
        checks++;
        if (rspValid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got rspValid=%b want 0", rspValid);
        end
    endtask

    task automatic test_round_robin();
        int             n;
        int             g;
        int             prev_cyc;
        bit             seen;
        logic [2*W-1:0] expd;
        prev_cyc = 0;
        rspReady = 1'b1;
        reqValid = 4'b1111;
        for (int i = 0; i < N; i++) rand_req(i);
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            g = pick(reqValid, exp_ptr);
            checks++;
            if (reqReady !== onehot(g)) begin
                errors++;
                $display("FAIL rr_grant op%0d: got %b want %b", k, reqReady, onehot(g));
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev_cyc !== L + 3) begin
                    errors++;
                    $display("FAIL rr_period op%0d: got %0d want %0d", k, cyc - prev_cyc, L + 3);
                end
            end
            prev_cyc = cyc;
            expd = fmad_ref(m1[g], m2[g], ad[g], sb[g], ng[g]);
            tick();
            checks++;
            if (fmadStart !== 1'b1 || fmadMulIn1 !== m1[g] || fmadMulIn2 !== m2[g] || fmadAddIn !== ad[g]) begin
                errors++;
                $display("FAIL rr_issue op%0d: got st=%b %h %h %h want 1 %h %h %h", k, fmadStart,
                         fmadMulIn1, fmadMulIn2, fmadAddIn, m1[g], m2[g], ad[g]);
            end
            rand_req(g);
            wait_rsp(n, seen);
            checks++;
            if (seen !== 1'b0 || n !== L + 1) begin
                errors++;
                $display("FAIL rr_busy op%0d: got ready_seen=%b lat=%0d want 0 %0d", k, seen, n, L + 1);
            end
            checks++;
            if (rspId !== 2'(g) || rspData !== expd || rspErr !== 1'b0) begin
                errors++;
                $display("FAIL rr_rsp op%0d: got id=%0d d=%h e=%b want %0d %h 0", k, rspId, rspData,
                         rspErr, g, expd);
            end
            exp_ptr = (g + 1) % N;
        end
        reqValid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int             n;
        bit             seen;
        bit             bad_hold;
        bit             bad_rdy;
        logic [2*W-1:0] hold_d;
        logic [2*W-1:0] expd;
        rspReady = 1'b0;
        rand_req(3);
        expd = fmad_ref(m1[3], m2[3], ad[3], sb[3], ng[3]);
        reqValid = 4'b1000;
        wait_grant(n);
        checks++;
        if (reqReady !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant: got %b want 1000", reqReady);
        end
        tick();
        reqValid = 4'b1111;
        wait_rsp(n, seen);
        checks++;
        if (rspData !== expd || rspId !== 2'd3 || n !== L + 1) begin
            errors++;
            $display("FAIL bp_rsp: got d=%h id=%0d lat=%0d want %h 3 %0d", rspData, rspId, n, expd, L + 1);
        end
        hold_d   = expd;
        bad_hold = 1'b0;
        bad_rdy  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (rspValid !== 1'b1 || rspData !== hold_d || rspId !== 2'd3 || rspErr !== 1'b0) bad_hold = 1'b1;
            if (reqReady !== '0) bad_rdy = 1'b1;
        end
        checks++;
        if (bad_hold) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%h want 1 %h held", rspValid, rspData, hold_d);
        end
        checks++;
        if (bad_rdy) begin
            errors++;
            $display("FAIL bp_no_ready: got reqReady asserted want 0000 while stalled");
        end
        rspReady = 1'b1;
        tick();
        #1;
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b want 0 0001", rspValid, reqReady);
        end
        reqValid = '0;
        exp_ptr  = 0;
    endtask

    task automatic test_timeout();
        int             n;
        int             g;
        bit             seen;
        logic [2*W-1:0] expd;
        mdl_en   = 1'b0;
        rspReady = 1'b1;
        reqValid = 4'($urandom_range(1, 15));
        g = pick(reqValid, exp_ptr);
        wait_grant(n);
        checks++;
        if (reqReady !== onehot(g)) begin
            errors++;
            $display("FAIL tmo_grant: got %b want %b", reqReady, onehot(g));
        end
        tick();
        reqValid = '0;
        wait_rsp(n, seen);
        checks++;
        if (n !== TMO + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d want %0d cycles after issue", n, TMO + 1);
        end
        checks++;
        if (rspErr !== 1'b1 || rspData !== '0 || rspId !== 2'(g)) begin
            errors++;
            $display("FAIL tmo_rsp: got e=%b d=%h id=%0d want 1 0 %0d", rspErr, rspData, rspId, g);
        end
        exp_ptr = (g + 1) % N;
        tick();
        mdl_en   = 1'b1;
        reqValid = 4'($urandom_range(1, 15));
        g = pick(reqValid, exp_ptr);
        expd = fmad_ref(m1[g], m2[g], ad[g], sb[g], ng[g]);
        wait_grant(n);
        tick();
        reqValid = '0;
        wait_rsp(n, seen);
        checks++;
        if (rspErr !== 1'b0 || rspData !== expd || rspId !== 2'(g)) begin
            errors++;
            $display("FAIL tmo_recover: got e=%b d=%h id=%0d want 0 %h %0d", rspErr, rspData, rspId, expd, g);
        end
        exp_ptr = (g + 1) % N;
        tick();
    endtask

    task automatic test_random_traffic();
        int             n;
        int             g;
        int             d;
        bit             seen;
        logic [2*W-1:0] expd;
        for (int k = 0; k < 12; k++) begin
            rspReady = 1'b0;
            reqValid = 4'($urandom_range(1, 15));
            g = pick(reqValid, exp_ptr);
            expd = fmad_ref(m1[g], m2[g], ad[g], sb[g], ng[g]);
            wait_grant(n);
            checks++;
            if (reqReady !== onehot(g)) begin
                errors++;
                $display("FAIL rnd_grant op%0d: got %b want %b mask %b", k, reqReady, onehot(g), reqValid);
            end
            tick();
            reqValid = '0;
            rand_req(g);
            wait_rsp(n, seen);
            checks++;
            if (rspId !== 2'(g) || rspData !== expd || rspErr !== 1'b0) begin
                errors++;
                $display("FAIL rnd_rsp op%0d: got id=%0d d=%h e=%b want %0d %h 0", k, rspId, rspData,
                         rspErr, g, expd);
            end
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) tick();
            rspReady = 1'b1;
            tick();
            exp_ptr = (g + 1) % N;
        end
        rspReady = 1'b1;
    endtask

    task automatic test_flags_stray();
        int  n;
        bit  bad;
        bit  bad_start;
        bit  got_rsp;
        m1[2] = 8'hFF; m2[2] = 8'hFF; ad[2] = 16'hFFFF; sb[2] = 1'b1; ng[2] = 1'b1;
        reqValid = 4'b0100;
        wait_grant(n);
        checks++;
        if (reqReady !== 4'b0100) begin
            errors++;
            $display("FAIL flag_grant: got %b want 0100", reqReady);
        end
        tick();
        reqValid = '0;
        bad       = 1'b0;
        bad_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rspValid) break;
            if (fmadSub !== 1'b1 || fmadNegate !== 1'b1 || fmadMulIn1 !== 8'hFF ||
                fmadMulIn2 !== 8'hFF || fmadAddIn !== 16'hFFFF) bad = 1'b1;
            if ((i == 0) != (fmadStart === 1'b1)) bad_start = 1'b1;
            tick();
        end
        checks++;
        if (bad || bad_start) begin
            errors++;
            $display("FAIL flag_hold: got hold_err=%b start_err=%b want 0 0", bad, bad_start);
        end
        checks++;
        if (rspValid !== 1'b1 || rspData !== 16'h01FE || rspId !== 2'd2) begin
            errors++;
            $display("FAIL flag_rsp: got v=%b d=%h id=%0d want 1 01fe 2", rspValid, rspData, rspId);
        end
        exp_ptr = 3;
        tick();
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        got_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rspValid !== 1'b0) got_rsp = 1'b1;
        end
        checks++;
        if (got_rsp) begin
            errors++;
            $display("FAIL stray_done: got rspValid=1 want 0 after idle done pulse");
        end
    endtask

    task automatic test_reset_in_wait();
        int             n;
        bit             seen;
        logic [2*W-1:0] expd;
        m1[3] = 8'hA5; m2[3] = 8'h5A; ad[3] = 16'h1234; sb[3] = 1'b1; ng[3] = 1'b0;
        reqValid = 4'b1000;
        wait_grant(n);
        checks++;
        if (reqReady !== 4'b1000) begin
            errors++;
            $display("FAIL arst_grant: got %b want 1000", reqReady);
        end
        tick();
        reqValid = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (fmadMulIn1 !== '0 || fmadMulIn2 !== '0 || fmadAddIn !== '0 || fmadSub !== 1'b0 ||
            rspId !== '0 || rspValid !== 1'b0 || fmadStart !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear: got %h %h %h %b id=%0d v=%b st=%b want all 0", fmadMulIn1,
                     fmadMulIn2, fmadAddIn, fmadSub, rspId, rspValid, fmadStart);
        end
        tick();
        tick();
        tick();
        checks++;
        if (rspValid !== 1'b0) begin
            errors++;
            $display("FAIL arst_no_rsp: got rspValid=%b want 0", rspValid);
        end
        reset_n = 1'b1;
        exp_ptr = 0;
        reqValid = 4'b1111;
        #1;
        checks++;
        if (reqReady !== 4'b0001) begin
            errors++;
            $display("FAIL arst_ptr: got %b want 0001", reqReady);
        end
        reqValid = 4'b0010;
        rand_req(1);
        expd = fmad_ref(m1[1], m2[1], ad[1], sb[1], ng[1]);
        #1;
        checks++;
        if (reqReady !== 4'b0010) begin
            errors++;
            $display("FAIL arst_req1: got %b want 0010", reqReady);
        end
        tick();
        reqValid = '0;
        wait_rsp(n, seen);
        checks++;
        if (n !== L + 1 || rspId !== 2'd1 || rspData !== expd || rspErr !== 1'b0) begin
            errors++;
            $display("FAIL arst_op: got lat=%0d id=%0d d=%h e=%b want %0d 1 %h 0", n, rspId, rspData,
                     rspErr, L + 1, expd);
        end
        tick();
    endtask

    initial begin
        fmadDone = 1'b0;
        fmadOut  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_random_traffic();
        test_flags_stray();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
